// File: rtl/ft600_slv_pkg.sv
// Shared types and constants for the FT600 245-sync FIFO responder.
package ft600_slv_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned ENTRY_W = BE_W + DATA_W;

    localparam logic [BE_W-1:0]   BE_FULL   = 4'hF;
    localparam logic [DATA_W-1:0] IDLE_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RD   = 3'b010,
        WR   = 3'b100
    } state_t;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/ft600_slv_fifo_resp_fifo.sv
// Synchronous FIFO, one push and one pop per cycle, with a registered head entry.
module slv_sync_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned W  = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [AW:0]  count_nxt_c
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   count;
    logic [AW:0]   cnt_after_pop;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        full          = (count == (AW+1)'(DEPTH));
        empty         = (count == '0);
        push_ok       = push & ~full;
        pop_ok        = pop & ~empty;
        rd_ptr_nxt    = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        cnt_after_pop = count - (AW+1)'(pop_ok);
        count_nxt_c   = cnt_after_pop + (AW+1)'(push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is prefetched: an entry written into an otherwise empty FIFO bypasses the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt_c;
            head   <= (cnt_after_pop == '0) ? push_data : mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/ft600_slv_fifo_resp.sv
// FT600 245-sync FIFO chip-side responder with RX/TX buffering and protocol checking.
// Optional forced flag stalls are enabled by defining FT600_SLV_STALL_EN.
module ft600_slv_fifo_resp
    import ft600_slv_pkg::*;
#(
    parameter int unsigned AW           = 4,
    parameter int unsigned STALL_PERIOD = 64,
    parameter int unsigned STALL_LEN    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_n,
    input  logic                rd_n,
    input  logic                oe_n,
    input  logic                dt_oe_n,
    input  logic [DATA_W-1:0]   mst_data,
    input  logic [BE_W-1:0]     mst_be,
    output logic [DATA_W-1:0]   slv_data,
    output logic [BE_W-1:0]     slv_be,
    output logic                rxf_n,
    output logic                txe_n,
    input  logic                h_rx_vld,
    input  logic [ENTRY_W-1:0]  h_rx_dat,
    output logic                h_rx_rdy,
    output logic                h_tx_vld,
    output logic [ENTRY_W-1:0]  h_tx_dat,
    input  logic                h_tx_rdy,
    output logic                short_pkt,
    output logic                proto_err
);
    localparam int unsigned DEPTH = 2 ** AW;

    state_t             state;
    state_t             state_nxt;
    logic               rd_acc;
    logic               wr_acc;
    logic               err_c;
    logic               stall_c;
    logic [ENTRY_W-1:0] rx_head_raw;
    entry_t             rx_head;
    entry_t             tx_in;
    logic [AW:0]        rx_cnt_nxt;
    logic [AW:0]        tx_cnt_nxt;

    assign rd_acc  = ~rd_n & ~oe_n & ~rxf_n;
    assign wr_acc  = ~wr_n & ~txe_n;
    assign err_c   = (~wr_n & ~oe_n) | (~dt_oe_n & ~oe_n) | (~rd_n & oe_n);
    assign rx_head = entry_t'(rx_head_raw);
    assign tx_in   = '{be: mst_be, data: mst_data};

    slv_sync_fifo #(.AW(AW), .W(ENTRY_W)) u_rx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (h_rx_vld & h_rx_rdy),
        .push_data   (h_rx_dat),
        .pop         (rd_acc),
        .head        (rx_head_raw),
        .count_nxt_c (rx_cnt_nxt)
    );

    slv_sync_fifo #(.AW(AW), .W(ENTRY_W)) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (wr_acc),
        .push_data   (tx_in),
        .pop         (h_tx_vld & h_tx_rdy),
        .head        (h_tx_dat),
        .count_nxt_c (tx_cnt_nxt)
    );

`ifdef FT600_SLV_STALL_EN
    localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    assign stall_c = (stall_cnt < SW'(STALL_LEN));
`else
    // Stall parameters only shape the stall build; here they fold to a constant zero.
    assign stall_c = 1'b0 & (STALL_LEN > STALL_PERIOD);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Conflicting oe_n/wr_n in IDLE holds the FSM; the error flag records it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!oe_n && !wr_n) begin
                    state_nxt = IDLE;
                end else if (!oe_n) begin
                    state_nxt = RD;
                end else if (!wr_n) begin
                    state_nxt = WR;
                end
            end
            RD:      if (oe_n) state_nxt = IDLE;
            WR:      if (wr_n) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxf_n     <= 1'b1;
            txe_n     <= 1'b1;
            slv_data  <= IDLE_DATA;
            slv_be    <= BE_FULL;
            h_rx_rdy  <= 1'b0;
            h_tx_vld  <= 1'b0;
            short_pkt <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rxf_n     <= (rx_cnt_nxt == '0) | (state == WR) | stall_c;
            txe_n     <= (tx_cnt_nxt == (AW+1)'(DEPTH)) | (state == RD) | stall_c;
            h_rx_rdy  <= (rx_cnt_nxt != (AW+1)'(DEPTH));
            h_tx_vld  <= (tx_cnt_nxt != '0);
            short_pkt <= wr_acc & (mst_be != BE_FULL);
            proto_err <= proto_err | err_c;
            if (rd_acc) begin
                slv_be   <= rx_head.be;
                slv_data <= rx_head.data;
            end
        end
    end

endmodule

// File: tb/tb_ft600_slv_fifo_resp.sv
// Scoreboard bench for ft600_slv_fifo_resp: directed bursts, full/empty edges, reset and protocol errors.
module tb_ft600_slv_fifo_resp;
    localparam int unsigned AW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_n;
    logic        rd_n;
    logic        oe_n;
    logic        dt_oe_n;
    logic [31:0] mst_data;
    logic [3:0]  mst_be;
    logic [31:0] slv_data;
    logic [3:0]  slv_be;
    logic        rxf_n;
    logic        txe_n;
    logic        h_rx_vld;
    logic [35:0] h_rx_dat;
    logic        h_rx_rdy;
    logic        h_tx_vld;
    logic [35:0] h_tx_dat;
    logic        h_tx_rdy;
    logic        short_pkt;
    logic        proto_err;

    int n_pass = 0;
    int n_tot  = 0;

    logic [35:0] rx_q[$];
    logic [35:0] tx_q[$];
    logic        sp_q[$];
    logic        rd_pend = 1'b0;
    logic [35:0] exp_w;

    always #5 clk = ~clk;

    ft600_slv_fifo_resp #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .oe_n      (oe_n),
        .dt_oe_n   (dt_oe_n),
        .mst_data  (mst_data),
        .mst_be    (mst_be),
        .slv_data  (slv_data),
        .slv_be    (slv_be),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .h_rx_vld  (h_rx_vld),
        .h_rx_dat  (h_rx_dat),
        .h_rx_rdy  (h_rx_rdy),
        .h_tx_vld  (h_tx_vld),
        .h_tx_dat  (h_tx_dat),
        .h_tx_rdy  (h_tx_rdy),
        .short_pkt (short_pkt),
        .proto_err (proto_err)
    );

    function automatic void chk(string name, logic [35:0] act, logic [35:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the expectation queues.
    always @(negedge clk) begin
        if (rd_pend) begin
            chk("rd_expected", 36'(rx_q.size() != 0), 36'd1);
            if (rx_q.size() != 0) begin
                exp_w = rx_q.pop_front();
                chk("rd_data", {slv_be, slv_data}, exp_w);
            end
        end
        rd_pend = rst_n & ~rd_n & ~oe_n & ~rxf_n;
        if (rst_n && h_tx_vld && h_tx_rdy) begin
            chk("tx_expected", 36'(tx_q.size() != 0), 36'd1);
            if (tx_q.size() != 0) begin
                exp_w = tx_q.pop_front();
                chk("tx_data", h_tx_dat, exp_w);
            end
        end
        if (rst_n && short_pkt) begin
            chk("short_expected", 36'(sp_q.size() != 0), 36'd1);
            if (sp_q.size() != 0) void'(sp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; dt_oe_n = 1'b1;
        mst_data = '0; mst_be = 4'hF; h_rx_vld = 1'b0; h_rx_dat = '0; h_tx_rdy = 1'b0;
        tick(); tick();

        chk("rst_rxf_n", 36'(rxf_n), 36'd1);
        chk("rst_txe_n", 36'(txe_n), 36'd1);
        chk("rst_slv_data", 36'(slv_data), 36'hFFFF_FFFF);
        chk("rst_slv_be", 36'(slv_be), 36'hF);
        chk("rst_h_rx_rdy", 36'(h_rx_rdy), 36'd0);
        chk("rst_h_tx_vld", 36'(h_tx_vld), 36'd0);
        chk("rst_short_pkt", 36'(short_pkt), 36'd0);
        chk("rst_proto_err", 36'(proto_err), 36'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_rxf_n", 36'(rxf_n), 36'd1);
        chk("idle_txe_n", 36'(txe_n), 36'd0);
        chk("idle_h_rx_rdy", 36'(h_rx_rdy), 36'd1);

        // Four-word read burst
        h_rx_vld = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            h_rx_dat = {4'hF, 32'(i)};
            rx_q.push_back(h_rx_dat);
            tick();
        end
        h_rx_vld = 1'b0;
        chk("rxf_after_push", 36'(rxf_n), 36'd0);
        oe_n = 1'b0;
        tick();
        rd_n = 1'b0;
        tick();
        chk("txe_forced_in_rd", 36'(txe_n), 36'd1);
        tick(); tick();
        chk("rxf_one_left", 36'(rxf_n), 36'd0);
        tick();
        chk("rxf_after_4th_pop", 36'(rxf_n), 36'd1);
        tick();
        chk("no_err_rd_empty", 36'(proto_err), 36'd0);
        chk("slv_hold_last", {slv_be, slv_data}, 36'hF_0000_0004);
        rd_n = 1'b1; oe_n = 1'b1;
        tick(); tick();

        // Fill TX, then a 17th strobe while full
        wr_n = 1'b0; mst_be = 4'hF;
        for (int i = 0; i < 17; i++) begin
            mst_data = 32'h100 + 32'(i);
            if (i < 16) tx_q.push_back({4'hF, mst_data});
            tick();
            if (i == 14) chk("txe_15_words", 36'(txe_n), 36'd0);
            if (i == 15) chk("txe_full", 36'(txe_n), 36'd1);
        end
        chk("no_err_wr_full", 36'(proto_err), 36'd0);
        wr_n = 1'b1;
        tick();
        h_tx_rdy = 1'b1;
        for (int k = 0; k < 40 && h_tx_vld; k++) tick();
        h_tx_rdy = 1'b0;
        chk("tx_drained", 36'(h_tx_vld), 36'd0);
        tick();
        chk("txe_after_drain", 36'(txe_n), 36'd0);

        // Short packet
        wr_n = 1'b0; mst_data = 32'h36; mst_be = 4'h1;
        tx_q.push_back(36'h1_0000_0036);
        sp_q.push_back(1'b1);
        tick();
        wr_n = 1'b1; mst_be = 4'hF;
        chk("short_head", h_tx_dat, 36'h1_0000_0036);
        chk("short_pulse", 36'(short_pkt), 36'd1);
        tick();
        chk("short_once", 36'(short_pkt), 36'd0);
        h_tx_rdy = 1'b1;
        tick();
        h_tx_rdy = 1'b0;
        chk("short_drained", 36'(h_tx_vld), 36'd0);

        // Fill RX (17th push dropped), one TX word, read 13, reset with 3 left
        h_rx_vld = 1'b1;
        for (int i = 0; i < 17; i++) begin
            h_rx_dat = {4'(i), 32'hA0 + 32'(i)};
            if (i < 16) rx_q.push_back(h_rx_dat);
            tick();
            if (i == 15) chk("rx_full_rdy", 36'(h_rx_rdy), 36'd0);
        end
        h_rx_vld = 1'b0;
        wr_n = 1'b0; mst_data = 32'h77;
        tx_q.push_back({4'hF, 32'h77});
        tick();
        wr_n = 1'b1;
        tick(); tick();
        chk("tx_vld_before_rst", 36'(h_tx_vld), 36'd1);
        oe_n = 1'b0;
        tick();
        rd_n = 1'b0;
        repeat (13) tick();
        chk("rxf_3_left", 36'(rxf_n), 36'd0);
        rst_n = 1'b0; rd_n = 1'b1; oe_n = 1'b1;
        tick();
        rx_q.delete(); tx_q.delete();
        chk("midrst_rxf_n", 36'(rxf_n), 36'd1);
        chk("midrst_h_tx_vld", 36'(h_tx_vld), 36'd0);
        chk("midrst_h_rx_rdy", 36'(h_rx_rdy), 36'd0);
        chk("midrst_slv", {slv_be, slv_data}, 36'hF_FFFF_FFFF);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rx_empty", 36'(rxf_n), 36'd1);
        chk("post_rst_tx_empty", 36'(h_tx_vld), 36'd0);
        chk("post_rst_h_rx_rdy", 36'(h_rx_rdy), 36'd1);
        chk("post_rst_txe_n", 36'(txe_n), 36'd0);

        // Each protocol violation sets a sticky error cleared only by reset
        for (int c = 0; c < 3; c++) begin
            chk("err_clear", 36'(proto_err), 36'd0);
            case (c)
                0:       begin wr_n = 1'b0; oe_n = 1'b0; end
                1:       begin dt_oe_n = 1'b0; oe_n = 1'b0; end
                default: begin rd_n = 1'b0; oe_n = 1'b1; end
            endcase
            tick();
            wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; dt_oe_n = 1'b1;
            chk("err_set", 36'(proto_err), 36'd1);
            repeat (3) tick();
            chk("err_sticky", 36'(proto_err), 36'd1);
            rst_n = 1'b0;
            tick();
            rx_q.delete(); tx_q.delete();
            rst_n = 1'b1;
            tick();
        end
        chk("err_cleared_by_rst", 36'(proto_err), 36'd0);

        chk("rx_q_empty", 36'(rx_q.size()), 36'd0);
        chk("tx_q_empty", 36'(tx_q.size()), 36'd0);
        chk("sp_q_empty", 36'(sp_q.size()), 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
